// File: rtl/minicpu_bus_responder_if.sv
// minicpu_bus_responder_if: MiniCPU memory bus plus interrupt handshake
interface minicpu_bus_responder_if #(parameter int NIRQ = 4);
  logic            IF, Rd, Wr;
  logic [15:0]     MAO;
  logic [7:0]      MDO, MDI;
  logic            Rdy;
  logic [NIRQ-1:0] Irq;
  logic            Int, Ack;
  logic [15:0]     Vector;
  logic            BusErr;
  modport master (output IF, Rd, Wr, MAO, MDO, Irq, Ack, input MDI, Rdy, Int, Vector, BusErr);
  modport slave  (input IF, Rd, Wr, MAO, MDO, Irq, Ack, output MDI, Rdy, Int, Vector, BusErr);
endinterface

// File: rtl/minicpu_bus_responder.sv
// minicpu_bus_responder: RAM window with wait states and edge-triggered interrupt block for MiniCPU
module minicpu_bus_responder #(
  parameter int          AW       = 10,
  parameter logic [15:0] MEM_BASE = 16'h0000,
  parameter int          RD_WAIT  = 1,
  parameter int          WR_WAIT  = 0,
  parameter int          NIRQ     = 4,
  parameter logic [15:0] RST_VEC  = 16'hFFFE,
  parameter logic [15:0] IRQ_VEC  = 16'hFFFC
) (
  input logic Clk,
  input logic Rst,
  minicpu_bus_responder_if.slave bus
);
  localparam int SW = NIRQ > 1 ? $clog2(NIRQ) : 1;
  generate
    if (RD_WAIT > 15 || WR_WAIT > 15 || RD_WAIT < 0 || WR_WAIT < 0) begin : g_bad_wait
      $error("wait-state parameters must be 0..15");
    end
  endgenerate
  logic [7:0]      mem [2**AW];
  logic [3:0]      wcnt;
  logic            req, hit;
  logic [AW-1:0]   idx;
  logic [NIRQ-1:0] irq_d, pend, pend_nxt, clr;
  logic [SW-1:0]   sel, sel_nxt, low;
  assign req     = bus.IF | bus.Rd | bus.Wr;
  assign hit     = bus.MAO[15:AW] == MEM_BASE[15:AW];
  assign idx     = bus.MAO[AW-1:0];
  assign bus.Rdy = ~req | ~hit | (wcnt == (bus.Wr ? 4'(WR_WAIT) : 4'(RD_WAIT)));
  assign bus.MDI = hit ? mem[idx] : 8'h00;
  // A fresh rising edge overrides an acknowledge of the same source
  always_comb begin
    clr      = bus.Ack ? NIRQ'(1) << sel : '0;
    pend_nxt = (pend & ~clr) | (bus.Irq & ~irq_d);
    low      = '0;
    for (int i = NIRQ - 1; i >= 0; i--) low = pend_nxt[i] ? SW'(i) : low;
    sel_nxt  = bus.Ack ? sel : low;
  end
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wcnt       <= '0;
      irq_d      <= '0;
      pend       <= '0;
      sel        <= '0;
      bus.Int    <= 1'b0;
      bus.Vector <= RST_VEC;
      bus.BusErr <= 1'b0;
    end else begin
      wcnt       <= (!req || bus.Rdy) ? 4'd0 : wcnt + {3'd0, wcnt != 4'hF};
      irq_d      <= bus.Irq;
      pend       <= pend_nxt;
      sel        <= sel_nxt;
      bus.Int    <= |pend_nxt;
      bus.Vector <= |pend_nxt ? IRQ_VEC - 16'({sel_nxt, 1'b0}) : RST_VEC;
      bus.BusErr <= req & ~hit & bus.Rdy;
    end
  end
  // RAM contents deliberately survive reset
  always_ff @(posedge Clk) begin
    if (bus.Wr & hit & bus.Rdy) mem[idx] <= bus.MDO;
  end
endmodule
